calc_io_sequencer: RTL and testbench

- Parametrised keypad-to-CPU calculator front end; successor to the fixed two-digit operand/opcode entry controller.
- Collects up to DIGITS-digit BCD operands and an opcode from decoded key events.
- Converts operands to binary and writes them to CPU data memory over a req/ack bus, then runs the CPU until halt or timeout.
- Reads the result back, converts it to BCD and drives a leading-zero-blanked display; adds backspace, clear, recall, overflow and timeout error handling.

---
 rtl/calc_io_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_calc_io_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_io_sequencer.sv
// Keypad calculator front end: BCD operand/opcode entry, bus writes to CPU data memory, CPU run/halt, result readback and display.
// Bus accesses are req/ack: a request is held until ack, and a clear pressed mid-transfer waits for that ack.
module calc_io_sequencer #(
  parameter int          DIGITS     = 4,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] ADDR_OP1   = 32'd220,
  parameter logic [31:0] ADDR_OP2   = 32'd240,
  parameter logic [31:0] ADDR_OP    = 32'd260,
  parameter logic [31:0] ADDR_RES   = 32'd280,
  parameter logic [31:0] ADDR_IDLE  = 32'd320,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          TIMEOUT    = 1048576
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  key_valid,
  input  logic [4:0]            key_code,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  bus_ack,
  output logic [31:0]           address,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic                  cpu_en,
  output logic                  cpu_nrst,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic [DIGITS-1:0]     disp_blank,
  output logic                  error
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [3:0] {
    S_NUM1, S_OPSEL, S_NUM2, S_CVT, S_WR, S_RUN, S_READ, S_DAB, S_DISPLAY, S_ERROR
  } state_t;

  typedef enum logic [1:0] {T_OP1, T_OP, T_OP2} tgt_t;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(pow10(DIGITS) - 1);

  function automatic logic [3:0] sig_digits(input logic [BW-1:0] v);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'd0) n = 4'(i + 1);
    return n;
  endfunction

  function automatic logic [DIGITS-1:0] blank_mask(input logic [3:0] n);
    logic [DIGITS-1:0] m;
    for (int i = 0; i < DIGITS; i++) m[i] = (4'(i) >= n);
    return m;
  endfunction

  state_t              r_state, w_state;
  tgt_t                r_tgt, w_tgt;
  logic [BW-1:0]       r_bcd, w_bcd, r_last, w_last, r_dab_bcd, w_dab_bcd;
  logic [3:0]          r_cnt, w_cnt, r_idx, w_idx;
  logic [1:0]          r_op, w_op;
  logic [DATA_W-1:0]   r_bin, w_bin, r_wdat, w_wdat;
  logic [31:0]         r_tmo, w_tmo, r_addr, w_addr;
  logic [7:0]          r_dab_cnt, w_dab_cnt;
  logic                r_clr_pend, w_clr_pend, r_req, w_req, r_we, w_we;
  logic                r_cpu_en, r_cpu_nrst, r_error;
  logic [BW-1:0]       r_disp_bcd, w_disp_bcd;
  logic [DIGITS-1:0]   r_disp_blank, w_disp_blank;
  logic                w_do_clr;

  logic                w_key_dig, w_key_rcl, w_key_clr, w_key_ent, w_key_bsp, w_key_op;
  logic [3:0]          w_dig;
  logic [DATA_W-1:0]   w_cvt_bin;
  logic [BW-1:0]       w_adj, w_dab_shift;

  assign w_key_dig = key_valid && (key_code < 5'd10);
  assign w_key_rcl = key_valid && (key_code == 5'd10);
  assign w_key_clr = key_valid && (key_code == 5'd11);
  assign w_key_ent = key_valid && (key_code == 5'd12);
  assign w_key_bsp = key_valid && (key_code == 5'd13);
  assign w_key_op  = key_valid && (key_code[4:2] == 3'b100);

  // MSD-first conversion: digit r_idx of the entry register feeds bin*10 + d
  always_comb begin
    w_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (r_idx == 4'(i)) w_dig = r_bcd[4*i +: 4];
  end

  assign w_cvt_bin = (r_bin << 3) + (r_bin << 1) + DATA_W'(w_dig);

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      w_adj[4*i +: 4] = (r_dab_bcd[4*i +: 4] >= 4'd5) ? r_dab_bcd[4*i +: 4] + 4'd3
                                                      : r_dab_bcd[4*i +: 4];
  end

  assign w_dab_shift = {w_adj[BW-2:0], r_bin[DATA_W-1]};

  always_comb begin
    w_state    = r_state;
    w_tgt      = r_tgt;
    w_bcd      = r_bcd;
    w_cnt      = r_cnt;
    w_op       = r_op;
    w_bin      = r_bin;
    w_idx      = r_idx;
    w_last     = r_last;
    w_tmo      = r_tmo;
    w_clr_pend = r_clr_pend;
    w_dab_cnt  = r_dab_cnt;
    w_dab_bcd  = r_dab_bcd;
    w_req      = r_req;
    w_we       = r_we;
    w_addr     = r_addr;
    w_wdat     = r_wdat;
    w_do_clr   = 1'b0;

    case (r_state)
      S_NUM1, S_NUM2: begin
        if (w_key_clr) begin
          w_do_clr = 1'b1;
        end else if (w_key_dig) begin
          if (r_cnt < 4'(DIGITS)) begin
            w_bcd = (r_bcd << 4) | BW'(key_code[3:0]);
            w_cnt = r_cnt + 4'd1;
          end
        end else if (w_key_bsp) begin
          if (r_cnt != 4'd0) begin
            w_bcd = r_bcd >> 4;
            w_cnt = r_cnt - 4'd1;
          end
        end else if (w_key_rcl && (r_state == S_NUM1)) begin
          w_bcd = r_last;
          w_cnt = sig_digits(r_last);
        end else if (w_key_ent) begin
          w_state = S_CVT;
          w_bin   = '0;
          w_idx   = 4'(DIGITS - 1);
          w_tgt   = (r_state == S_NUM1) ? T_OP1 : T_OP2;
        end
      end

      S_OPSEL: begin
        if (w_key_clr) begin
          w_do_clr = 1'b1;
        end else if (w_key_op) begin
          w_op = key_code[1:0];
        end else if (w_key_ent) begin
          w_state = S_WR;
          w_tgt   = T_OP;
          w_req   = 1'b1;
          w_we    = 1'b1;
          w_addr  = ADDR_OP;
          w_wdat  = DATA_W'(r_op);
        end
      end

      S_CVT: begin
        if (w_key_clr) begin
          w_do_clr = 1'b1;
        end else begin
          w_bin = w_cvt_bin;
          if (r_idx == 4'd0) begin
            w_state = S_WR;
            w_req   = 1'b1;
            w_we    = 1'b1;
            w_addr  = (r_tgt == T_OP1) ? ADDR_OP1 : ADDR_OP2;
            w_wdat  = w_cvt_bin;
          end else begin
            w_idx = r_idx - 4'd1;
          end
        end
      end

      S_WR: begin
        if (bus_ack) begin
          w_req = 1'b0;
          w_we  = 1'b0;
          if (r_clr_pend || w_key_clr) begin
            w_do_clr = 1'b1;
          end else begin
            w_bcd = '0;
            w_cnt = 4'd0;
            case (r_tgt)
              T_OP1:   w_state = S_OPSEL;
              T_OP:    w_state = S_NUM2;
              default: begin
                w_state = S_RUN;
                w_tmo   = 32'd0;
              end
            endcase
          end
        end else if (w_key_clr) begin
          w_clr_pend = 1'b1;
        end
      end

      S_RUN: begin
        if (w_key_clr) begin
          w_do_clr = 1'b1;
        end else if (instruction == HALT_INSTR) begin
          w_state = S_READ;
          w_req   = 1'b1;
          w_we    = 1'b0;
          w_addr  = ADDR_RES;
        end else if (r_tmo == 32'(TIMEOUT - 1)) begin
          w_state = S_ERROR;
        end else begin
          w_tmo = r_tmo + 32'd1;
        end
      end

      S_READ: begin
        if (bus_ack) begin
          w_req = 1'b0;
          if (r_clr_pend || w_key_clr) begin
            w_do_clr = 1'b1;
          end else if (rd_data > MAX_VAL) begin
            w_state = S_ERROR;
          end else begin
            w_state   = S_DAB;
            w_bin     = rd_data;
            w_dab_bcd = '0;
            w_dab_cnt = 8'd0;
          end
        end else if (w_key_clr) begin
          w_clr_pend = 1'b1;
        end
      end

      S_DAB: begin
        if (w_key_clr) begin
          w_do_clr = 1'b1;
        end else begin
          w_bin     = r_bin << 1;
          w_dab_bcd = w_dab_shift;
          if (r_dab_cnt == 8'(DATA_W - 1)) begin
            w_last  = w_dab_shift;
            w_state = S_DISPLAY;
          end else begin
            w_dab_cnt = r_dab_cnt + 8'd1;
          end
        end
      end

      S_DISPLAY: begin
        if (w_key_clr) begin
          w_do_clr = 1'b1;
        end else if (w_key_dig) begin
          w_state = S_NUM1;
          w_bcd   = BW'(key_code[3:0]);
          w_cnt   = 4'd1;
          w_op    = 2'd0;
          w_bin   = '0;
        end else if (w_key_ent) begin
          w_state = S_NUM1;
          w_bcd   = '0;
          w_cnt   = 4'd0;
          w_op    = 2'd0;
          w_bin   = '0;
        end
      end

      S_ERROR: begin
        if (w_key_clr) w_do_clr = 1'b1;
      end

      default: w_do_clr = 1'b1;
    endcase

    if (w_do_clr) begin
      w_state    = S_NUM1;
      w_bcd      = '0;
      w_cnt      = 4'd0;
      w_op       = 2'd0;
      w_bin      = '0;
      w_clr_pend = 1'b0;
      w_req      = 1'b0;
      w_we       = 1'b0;
    end
  end

  always_comb begin
    w_disp_bcd   = r_disp_bcd;
    w_disp_blank = r_disp_blank;
    case (w_state)
      S_NUM1, S_NUM2: begin
        w_disp_bcd   = w_bcd;
        w_disp_blank = blank_mask((w_cnt == 4'd0) ? 4'd1 : w_cnt);
      end
      S_OPSEL: begin
        w_disp_bcd   = BW'(w_op);
        w_disp_blank = blank_mask(4'd1);
      end
      S_DISPLAY: begin
        w_disp_bcd   = w_last;
        w_disp_blank = blank_mask(sig_digits(w_last));
      end
      S_ERROR:  w_disp_blank = '1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_NUM1;
      r_tgt        <= T_OP1;
      r_bcd        <= '0;
      r_cnt        <= 4'd0;
      r_op         <= 2'd0;
      r_bin        <= '0;
      r_idx        <= 4'd0;
      r_last       <= '0;
      r_tmo        <= 32'd0;
      r_clr_pend   <= 1'b0;
      r_dab_cnt    <= 8'd0;
      r_dab_bcd    <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= ADDR_IDLE;
      r_wdat       <= '0;
      r_cpu_en     <= 1'b0;
      r_cpu_nrst   <= 1'b0;
      r_error      <= 1'b0;
      r_disp_bcd   <= '0;
      r_disp_blank <= ~DIGITS'(1);
    end else begin
      r_state      <= w_state;
      r_tgt        <= w_tgt;
      r_bcd        <= w_bcd;
      r_cnt        <= w_cnt;
      r_op         <= w_op;
      r_bin        <= w_bin;
      r_idx        <= w_idx;
      r_last       <= w_last;
      r_tmo        <= w_tmo;
      r_clr_pend   <= w_clr_pend;
      r_dab_cnt    <= w_dab_cnt;
      r_dab_bcd    <= w_dab_bcd;
      r_req        <= w_req;
      r_we         <= w_we;
      r_addr       <= w_req ? w_addr : ADDR_IDLE;
      r_wdat       <= w_wdat;
      // CPU controls follow the state being entered so cpu_en falls on the exit edge
      r_cpu_en     <= (w_state == S_RUN);
      r_cpu_nrst   <= (w_state == S_RUN) || (w_state == S_READ);
      r_error      <= (w_state == S_ERROR);
      r_disp_bcd   <= w_disp_bcd;
      r_disp_blank <= w_disp_blank;
    end
  end

  assign address    = r_addr;
  assign wr_data    = r_wdat;
  assign bus_req    = r_req;
  assign bus_we     = r_we;
  assign cpu_en     = r_cpu_en;
  assign cpu_nrst   = r_cpu_nrst;
  assign error      = r_error;
  assign disp_bcd   = r_disp_bcd;
  assign disp_blank = r_disp_blank;

endmodule

// File: tb/tb_calc_io_sequencer.sv
// Directed bench for calc_io_sequencer: key sequences, a req/ack responder task and hand-computed expectations.
module tb_calc_io_sequencer;
  localparam int DIGITS = 4;
  localparam int DATA_W = 32;
  localparam int TMO    = 40;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic                clk = 1'b0;
  logic                nrst = 1'b0;
  logic                key_valid = 1'b0;
  logic [4:0]          key_code = 5'd0;
  logic [31:0]         instruction = 32'd0;
  logic [DATA_W-1:0]   rd_data = '0;
  logic                bus_ack = 1'b0;
  logic [31:0]         address;
  logic [DATA_W-1:0]   wr_data;
  logic                bus_req, bus_we, cpu_en, cpu_nrst, error;
  logic [4*DIGITS-1:0] disp_bcd;
  logic [DIGITS-1:0]   disp_blank;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_io_sequencer #(.DIGITS(DIGITS), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst), .key_valid(key_valid), .key_code(key_code),
    .instruction(instruction), .rd_data(rd_data), .bus_ack(bus_ack),
    .address(address), .wr_data(wr_data), .bus_req(bus_req), .bus_we(bus_we),
    .cpu_en(cpu_en), .cpu_nrst(cpu_nrst), .disp_bcd(disp_bcd),
    .disp_blank(disp_blank), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic show(input string tag, input logic [15:0] bcd, input logic [3:0] blank);
    check({tag, "_bcd"}, 32'(disp_bcd), 32'(bcd));
    check({tag, "_blank"}, 32'(disp_blank), 32'(blank));
  endtask

  // Waits (bounded) for a request, stalls, then acks once and checks the drop
  task automatic serve(input string tag, input int stall, input logic [31:0] rdat,
                       input logic [31:0] a_exp, input logic [31:0] d_exp, input logic we_exp);
    int n;
    n = 0;
    while (bus_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(bus_req), 32'd1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold"}, 32'(bus_req), 32'd1);
    end
    check({tag, "_addr"}, address, a_exp);
    check({tag, "_we"}, 32'(bus_we), 32'(we_exp));
    if (we_exp) check({tag, "_data"}, wr_data, d_exp);
    bus_ack = 1'b1;
    rd_data = rdat;
    tick();
    bus_ack = 1'b0;
    rd_data = '0;
    check({tag, "_drop"}, 32'(bus_req), 32'd0);
    check({tag, "_idle"}, address, 32'd320);
  endtask

  // From NUM1 with empty entry: operands 0, op 0, ends in RUN
  task automatic to_run(input string tag);
    press(5'd12);
    serve({tag, "_w1"}, 0, 0, 32'd220, 32'd0, 1'b1);
    press(5'd12);
    serve({tag, "_wo"}, 0, 0, 32'd260, 32'd0, 1'b1);
    press(5'd12);
    serve({tag, "_w2"}, 0, 0, 32'd240, 32'd0, 1'b1);
    check({tag, "_cpu_en"}, 32'(cpu_en), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", address, 32'd320);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_cpu_nrst", 32'(cpu_nrst), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_wdat", wr_data, 32'd0);
    show("rst", 16'h0000, 4'b1110);
    nrst = 1'b1;
    tick();

    // Fifth digit dropped, CVT takes 4 cycles, 3-cycle ack stall
    press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
    show("ent1234", 16'h1234, 4'b0000);
    press(5'd12);
    repeat (3) tick();
    check("cvt_busy", 32'(bus_req), 32'd0);
    tick();
    check("cvt_done", 32'(bus_req), 32'd1);
    serve("w1234", 3, 0, 32'd220, 32'd1234, 1'b1);
    show("opsel0", 16'h0000, 4'b1110);
    press(5'd11);

    // Backspace below zero is ignored
    press(5'd7);
    show("bs7", 16'h0007, 4'b1110);
    press(5'd13);
    show("bs_empty", 16'h0000, 4'b1110);
    press(5'd13);
    press(5'd9);
    show("bs9", 16'h0009, 4'b1110);
    press(5'd12);
    show("cvt_hold", 16'h0009, 4'b1110);
    serve("w9", 0, 0, 32'd220, 32'd9, 1'b1);
    press(5'd11);

    // 12 op1 30 -> 360
    press(5'd0); press(5'd0); press(5'd1); press(5'd2);
    show("op1", 16'h0012, 4'b0000);
    press(5'd12);
    serve("c_op1", 1, 0, 32'd220, 32'd12, 1'b1);
    press(5'd17);
    show("op_key", 16'h0001, 4'b1110);
    press(5'd12);
    serve("c_op", 0, 0, 32'd260, 32'd1, 1'b1);
    press(5'd0); press(5'd0); press(5'd3); press(5'd0);
    press(5'd12);
    serve("c_op2", 2, 0, 32'd240, 32'd30, 1'b1);
    check("run_en", 32'(cpu_en), 32'd1);
    check("run_nrst", 32'(cpu_nrst), 32'd1);
    press(5'd5);
    check("run_key_ign", 32'(cpu_en), 32'd1);
    instruction = HALT;
    tick();
    instruction = 32'd0;
    check("halt_en", 32'(cpu_en), 32'd0);
    check("halt_nrst", 32'(cpu_nrst), 32'd1);
    serve("c_rd", 0, 32'd360, 32'd280, 32'd0, 1'b0);
    check("dab_nrst", 32'(cpu_nrst), 32'd0);
    repeat (31) tick();
    show("dab_busy", 16'h0030, 4'b0000);
    tick();
    show("res360", 16'h0360, 4'b1000);

    // Overflow by one past the display range
    press(5'd12);
    show("new_entry", 16'h0000, 4'b1110);
    to_run("ovf");
    instruction = HALT;
    tick();
    instruction = 32'd0;
    serve("ovf_rd", 0, 32'd10000, 32'd280, 32'd0, 1'b0);
    check("ovf_err", 32'(error), 32'd1);
    check("ovf_blank", 32'(disp_blank), 32'hF);
    press(5'd5);
    check("err_key_ign", 32'(error), 32'd1);
    press(5'd11);
    check("clr_err", 32'(error), 32'd0);
    show("clr_disp", 16'h0000, 4'b1110);

    // Largest displayable result
    to_run("max");
    instruction = HALT;
    tick();
    instruction = 32'd0;
    serve("max_rd", 0, 32'd9999, 32'd280, 32'd0, 1'b0);
    check("max_err", 32'(error), 32'd0);
    repeat (32) tick();
    show("res9999", 16'h9999, 4'b0000);
    press(5'd11);

    // Timeout after TMO RUN cycles
    to_run("tmo");
    repeat (TMO - 1) tick();
    check("tmo_pre_err", 32'(error), 32'd0);
    check("tmo_pre_en", 32'(cpu_en), 32'd1);
    tick();
    check("tmo_err", 32'(error), 32'd1);
    check("tmo_en", 32'(cpu_en), 32'd0);
    check("tmo_nrst", 32'(cpu_nrst), 32'd0);
    press(5'd11);

    // Halt on the final timeout cycle wins
    to_run("hw");
    repeat (TMO - 1) tick();
    instruction = HALT;
    tick();
    instruction = 32'd0;
    check("hw_err", 32'(error), 32'd0);
    serve("hw_rd", 0, 32'd360, 32'd280, 32'd0, 1'b0);
    repeat (32) tick();
    show("hw_res", 16'h0360, 4'b1000);
    press(5'd11);

    // Clear during a stalled write waits for ack, then recall
    press(5'd4);
    press(5'd12);
    repeat (4) tick();
    check("cw_req", 32'(bus_req), 32'd1);
    press(5'd11);
    check("cw_hold1", 32'(bus_req), 32'd1);
    tick();
    check("cw_hold2", 32'(bus_req), 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("cw_drop", 32'(bus_req), 32'd0);
    show("cw_num1", 16'h0000, 4'b1110);
    press(5'd10);
    show("recall", 16'h0360, 4'b1000);
    press(5'd12);
    serve("rcl_w", 0, 0, 32'd220, 32'd360, 1'b1);

    // Asynchronous reset while the CPU runs
    press(5'd12);
    serve("rr_wo", 0, 0, 32'd260, 32'd0, 1'b1);
    press(5'd12);
    serve("rr_w2", 0, 0, 32'd240, 32'd0, 1'b1);
    check("rr_run", 32'(cpu_en), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("rr_en", 32'(cpu_en), 32'd0);
    check("rr_nrst", 32'(cpu_nrst), 32'd0);
    check("rr_addr", address, 32'd320);
    show("rr", 16'h0000, 4'b1110);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
